regfile_fwd_nstage: RTL and testbench

REGFILE_FWD_NSTAGE -- requirements
Module: regfile_fwd_nstage

---
 rtl/regfile_fwd_nstage.sv | 70 +++++++
 tb/tb_regfile_fwd_nstage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/regfile_fwd_nstage.sv
// regfile_fwd_nstage: register file with EX/MEM/WB operand forwarding, load-use stall and event counters
module regfile_fwd_nstage #(
  parameter int XLEN = 32,
  parameter int AW = 5,
  parameter int ZERO_REG = 1,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   ex_rd,
  input  logic            ex_regwrite,
  input  logic            ex_memtoreg,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [AW-1:0]   mem_rd,
  input  logic            mem_regwrite,
  input  logic            mem_memtoreg,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_load_data,
  input  logic [AW-1:0]   wb_rd,
  input  logic            wb_regwrite,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic [1:0]      fwd_sel1,
  output logic [1:0]      fwd_sel2,
  output logic            stall,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] fwd_cnt
);
  localparam int NREG = 1 << AW;
  logic [XLEN-1:0] regs [NREG];
  logic [1:0][AW-1:0] rs;
  logic [1:0][XLEN-1:0] rd_v;
  logic [1:0][1:0] sel;
  logic [1:0] ld_hit;
  logic fwd_evt;
  assign rs = {rs2, rs1};
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic z, ex_m, mem_m, wb_m;
    assign z = (ZERO_REG != 0) && (rs[p] == '0);
    assign ex_m = ex_regwrite && (ex_rd == rs[p]) && !z;
    assign mem_m = mem_regwrite && (mem_rd == rs[p]) && !z;
    assign wb_m = wb_regwrite && (wb_rd == rs[p]) && !z;
    assign ld_hit[p] = ex_m && ex_memtoreg;
    // a pending load in EX masks older producers; the port stalls and reads as array/zero select
    assign sel[p] = ex_m ? (ex_memtoreg ? 2'b00 : 2'b11) : mem_m ? 2'b10 : wb_m ? 2'b01 : 2'b00;
    assign rd_v[p] = ex_m ? (ex_memtoreg ? '0 : ex_alu_result)
                   : mem_m ? (mem_memtoreg ? mem_load_data : mem_alu_result)
                   : wb_m ? wb_data : z ? '0 : regs[rs[p]];
  end
  assign rdata1 = rd_v[0];
  assign rdata2 = rd_v[1];
  assign fwd_sel1 = sel[0];
  assign fwd_sel2 = sel[1];
  assign stall = |ld_hit;
  assign fwd_evt = !stall && (|sel[0] || |sel[1]);
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      stall_cnt <= '0;
      fwd_cnt <= '0;
    end else begin
      if (wb_regwrite && !((ZERO_REG != 0) && (wb_rd == '0))) regs[wb_rd] <= wb_data;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (fwd_evt && !(&fwd_cnt)) fwd_cnt <= fwd_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_fwd_nstage.sv
// tb_regfile_fwd_nstage: directed and randomized checks of three parameterizations against a behavioural model
module tb_regfile_fwd_nstage;
  logic clk = 0, rst;
  logic [4:0] rs1, rs2, ex_rd, mem_rd, wb_rd;
  logic ex_regwrite, ex_memtoreg, mem_regwrite, mem_memtoreg, wb_regwrite;
  logic [31:0] ex_alu_result, mem_alu_result, mem_load_data, wb_data;
  logic [31:0] r1, r2, nz_r1, nz_r2, c4_r1, c4_r2;
  logic [1:0] s1, s2, nz_s1, nz_s2, c4_s1, c4_s2;
  logic st, nz_st, c4_st;
  logic [15:0] sc, fc, nz_sc, nz_fc;
  logic [3:0] c4_sc, c4_fc;
  int checks = 0, errors = 0;
  logic [31:0] mz [32];
  logic [31:0] mnz [32];
  int esc16, efc16, esc4, efc4;

  always #5 clk = ~clk;

  regfile_fwd_nstage dut (.clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_alu_result(ex_alu_result),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
    .rdata1(r1), .rdata2(r2), .fwd_sel1(s1), .fwd_sel2(s2), .stall(st), .stall_cnt(sc), .fwd_cnt(fc));
  regfile_fwd_nstage #(.ZERO_REG(0)) dut_nz (.clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_alu_result(ex_alu_result),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
    .rdata1(nz_r1), .rdata2(nz_r2), .fwd_sel1(nz_s1), .fwd_sel2(nz_s2), .stall(nz_st), .stall_cnt(nz_sc), .fwd_cnt(nz_fc));
  regfile_fwd_nstage #(.CNTW(4)) dut_c4 (.clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_alu_result(ex_alu_result),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
    .rdata1(c4_r1), .rdata2(c4_r2), .fwd_sel1(c4_s1), .fwd_sel2(c4_s2), .stall(c4_st), .stall_cnt(c4_sc), .fwd_cnt(c4_fc));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // youngest producer wins; a load still in EX means stall instead of a value
  function automatic void ref_port(input bit zr, input logic [4:0] a, input logic [31:0] m [32],
                                   output logic [31:0] v, output logic [1:0] s, output bit ld);
    bit z = zr && a == 0;
    ld = 0;
    if (!z && ex_regwrite && ex_rd == a) begin
      ld = ex_memtoreg; s = ex_memtoreg ? 2'd0 : 2'd3; v = ex_alu_result;
    end else if (!z && mem_regwrite && mem_rd == a) begin
      s = 2'd2; v = mem_memtoreg ? mem_load_data : mem_alu_result;
    end else if (!z && wb_regwrite && wb_rd == a) begin
      s = 2'd1; v = wb_data;
    end else begin
      s = 2'd0; v = z ? 32'd0 : m[a];
    end
  endfunction

  task automatic settle();
    logic [31:0] v1, v2; logic [1:0] e1, e2; bit l1, l2;
    @(negedge clk);
    ref_port(1, rs1, mz, v1, e1, l1);
    ref_port(1, rs2, mz, v2, e2, l2);
    chk("stall", st, l1 | l2);
    chk("sel1", s1, e1);
    chk("sel2", s2, e2);
    if (!l1) chk("rdata1", r1, v1);
    if (!l2) chk("rdata2", r2, v2);
    chk("stall_cnt", sc, esc16);
    chk("fwd_cnt", fc, efc16);
    chk("c4_stall_cnt", c4_sc, esc4);
    chk("c4_fwd_cnt", c4_fc, efc4);
    ref_port(0, rs1, mnz, v1, e1, l1);
    ref_port(0, rs2, mnz, v2, e2, l2);
    chk("nz_stall", nz_st, l1 | l2);
    chk("nz_sel1", nz_s1, e1);
    chk("nz_sel2", nz_s2, e2);
    if (!l1) chk("nz_rdata1", nz_r1, v1);
    if (!l2) chk("nz_rdata2", nz_r2, v2);
  endtask

  task automatic tick();
    logic [31:0] v; logic [1:0] e1, e2; bit l1, l2;
    @(posedge clk);
    ref_port(1, rs1, mz, v, e1, l1);
    ref_port(1, rs2, mz, v, e2, l2);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin mz[i] = 0; mnz[i] = 0; end
      esc16 = 0; efc16 = 0; esc4 = 0; efc4 = 0;
    end else begin
      if (wb_regwrite) begin
        if (wb_rd != 0) mz[wb_rd] = wb_data;
        mnz[wb_rd] = wb_data;
      end
      if (l1 | l2) begin
        esc16 = esc16 < 65535 ? esc16 + 1 : esc16;
        esc4 = esc4 < 15 ? esc4 + 1 : esc4;
      end else if (e1 != 0 || e2 != 0) begin
        efc16 = efc16 < 65535 ? efc16 + 1 : efc16;
        efc4 = efc4 < 15 ? efc4 + 1 : efc4;
      end
    end
    #1;
  endtask

  task automatic idle();
    {ex_regwrite, ex_memtoreg, mem_regwrite, mem_memtoreg, wb_regwrite} = '0;
    {ex_rd, mem_rd, wb_rd} = '0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin mz[i] = 'x; mnz[i] = 'x; end
    esc16 = 0; efc16 = 0; esc4 = 0; efc4 = 0;
    idle();
    {ex_alu_result, mem_alu_result, mem_load_data, wb_data} = '0;
    rs1 = 0; rs2 = 0; rst = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin mz[i] = 0; mnz[i] = 0; end
    tick();
    rst = 0; rs1 = 3; rs2 = 7;
    settle();
    chk("r030_rdata1", r1, 0); chk("r030_rdata2", r2, 0); chk("r030_sel", {s1, s2}, 0);
    tick();
    wb_regwrite = 1; wb_rd = 5; wb_data = 32'hA5A5A5A5;
    settle(); tick();
    wb_regwrite = 0; rs1 = 5;
    settle(); chk("r031_arr", r1, 32'hA5A5A5A5); chk("r031_arr_sel", s1, 0); tick();
    wb_regwrite = 1; wb_data = 32'h11;
    settle(); chk("r031_wt", r1, 32'h11); chk("r031_wt_sel", s1, 1); tick();
    {ex_rd, mem_rd, wb_rd} = {5'd9, 5'd9, 5'd9};
    {ex_regwrite, mem_regwrite, wb_regwrite} = 3'b111;
    ex_alu_result = 1; mem_alu_result = 2; wb_data = 3; rs1 = 9;
    settle(); chk("r032_ex", r1, 1); chk("r032_ex_sel", s1, 3); tick();
    ex_regwrite = 0;
    settle(); chk("r032_mem", r1, 2); chk("r032_mem_sel", s1, 2); tick();
    mem_memtoreg = 1; mem_load_data = 32'h77;
    settle(); chk("r032_ld", r1, 32'h77); chk("r032_ld_sel", s1, 2); tick();
    idle(); rs1 = 0; rs2 = 4;
    ex_regwrite = 1; ex_memtoreg = 1; ex_rd = 4;
    for (int i = 0; i < 3; i++) begin settle(); chk("r033_stall", st, 1); tick(); end
    idle();
    settle(); chk("r033_stall_cnt", sc, 3); tick();
    wb_regwrite = 1; wb_rd = 0; wb_data = 32'hFFFF;
    ex_regwrite = 1; ex_rd = 0; ex_alu_result = 32'h1234; rs1 = 0;
    settle();
    chk("r034_z_rdata", r1, 0); chk("r034_z_sel", s1, 0); chk("r034_z_stall", st, 0);
    chk("r034_nz_rdata", nz_r1, 32'h1234); chk("r034_nz_sel", nz_s1, 3);
    tick();
    idle(); ex_regwrite = 1; ex_rd = 2; rs1 = 2;
    for (int i = 0; i < 20; i++) begin settle(); tick(); end
    settle(); chk("r035_sat", c4_fc, 15); tick();
    settle(); chk("r035_hold", c4_fc, 15);
    rst = 1; tick(); rst = 0;
    settle(); chk("r035_rst", c4_fc, 0); chk("r035_rst16", fc, 0); tick();
    for (int n = 0; n < 2000; n++) begin
      rst = $urandom_range(0, 40) == 0;
      rs1 = $urandom_range(0, 4); rs2 = $urandom_range(0, 4);
      ex_rd = $urandom_range(0, 4); mem_rd = $urandom_range(0, 4); wb_rd = $urandom_range(0, 4);
      ex_regwrite = $urandom; ex_memtoreg = $urandom_range(0, 3) == 0;
      mem_regwrite = $urandom; mem_memtoreg = $urandom;
      wb_regwrite = $urandom;
      ex_alu_result = $urandom; mem_alu_result = $urandom;
      mem_load_data = $urandom; wb_data = $urandom;
      settle(); tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
